// File: rtl/wave_capture_pkg.sv
// wave_capture_pkg: shared types and helpers for the triggered waveform capture.
// Holds the capture state enum, the decimation counter width and the sample
// truncation helper used on the incoming 24-bit audio words.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEC_CNT_W = 7;
    localparam int AUDIO_W   = 24;

    // Keep the top keep_w bits of a sample, right-aligned; no rounding or saturation.
    function automatic logic [AUDIO_W-1:0] truncate_sample(input logic [AUDIO_W-1:0] sample,
                                                          input int keep_w);
        return sample >> (AUDIO_W - keep_w);
    endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// wave_capture_ram: simple dual-port RAM, one write port and one registered
// read port on the same clock. The array itself has no reset so it maps onto
// block RAM; only the read output register clears on reset.
module wave_capture_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: one stereo word per accepted sample.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port: data for rd_addr appears after the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_capture.sv
// wave_capture: decimates and truncates the stereo audio stream and records a
// DEPTH-sample window around a rising level crossing, then freezes it for
// random-access readout until rearm.
// Optional feature macro: WAVE_CAPTURE_AUTOTRIG_EN forces a trigger after
// TIMEOUT samples written while armed and flags it on timed_out.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int DATA_W   = 12,
    parameter int PRE_TRIG = 128,
    parameter int TIMEOUT  = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_stb,
    input  logic [23:0]               audio_l,
    input  logic [23:0]               audio_r,
    input  logic [2:0]                dec_sel,
    input  logic                      trig_ch,
    input  logic signed [DATA_W-1:0]  trig_level,
    input  logic                      rearm,
    output logic                      busy,
    output logic                      done,
    output logic                      timed_out,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_l,
    output logic [DATA_W-1:0]         rd_r
);

    localparam int AW      = $clog2(DEPTH);
    localparam int SEG_MAX = (TIMEOUT > DEPTH) ? TIMEOUT : DEPTH;
    localparam int SEG_W   = $clog2(SEG_MAX) + 1;
    localparam logic [SEG_W-1:0] FILL_LEN = SEG_W'(PRE_TRIG);
    localparam logic [SEG_W-1:0] POST_LEN = SEG_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0]    PRE_OFS  = AW'(PRE_TRIG);

    state_e                     state_q, state_d;
    logic [DEC_CNT_W-1:0]       dec_cnt_q, dec_cnt_d;
    logic [2:0]                 dec_sel_q, dec_sel_d;
    logic [SEG_W-1:0]           seg_cnt_q, seg_cnt_d, seg_next;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              trig_ptr_q, trig_ptr_d;
    logic signed [DATA_W-1:0]   prev_l_q, prev_l_d, prev_r_q, prev_r_d;

    logic signed [DATA_W-1:0]   samp_l, samp_r, trig_cur, trig_prev;
    logic [2:0]                 dec_eff;
    logic [DEC_CNT_W-1:0]       dec_limit;
    logic                       wr_en, crossing;
    logic [AW-1:0]              rd_phys;
    logic [2*DATA_W-1:0]        rd_data;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam logic [SEG_W-1:0] TIMEOUT_LEN = SEG_W'(TIMEOUT);
    logic timed_out_q, timed_out_d;
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    assign samp_l = DATA_W'(truncate_sample(audio_l, DATA_W));
    assign samp_r = DATA_W'(truncate_sample(audio_r, DATA_W));

    // Decimation: dec_sel is captured on the strobe that opens each period, so a
    // period never changes length halfway through; only count 0 is written.
    always_comb begin
        dec_eff   = (dec_cnt_q == '0) ? dec_sel : dec_sel_q;
        dec_limit = DEC_CNT_W'((8'd1 << dec_eff) - 8'd1);
        dec_cnt_d = dec_cnt_q;
        dec_sel_d = dec_sel_q;
        if (rearm) begin
            dec_cnt_d = '0;
        end else if (sample_stb) begin
            if (dec_cnt_q == '0) begin
                dec_sel_d = dec_sel;
            end
            dec_cnt_d = (dec_cnt_q == dec_limit) ? '0 : dec_cnt_q + 1'b1;
        end
    end

    assign wr_en = sample_stb && !rearm && (dec_cnt_q == '0) && (state_q != DONE);

    assign trig_cur  = trig_ch ? samp_r : samp_l;
    assign trig_prev = trig_ch ? prev_r_q : prev_l_q;
    assign crossing  = (trig_prev < trig_level) && (trig_cur >= trig_level);

    // Capture FSM next state: every transition rides on the write that causes it,
    // and one segment counter serves FILL, ARMED (timeout) and POST in turn.
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        prev_l_d   = prev_l_q;
        prev_r_d   = prev_r_q;
        seg_next   = seg_cnt_q + 1'b1;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        timed_out_d = timed_out_q;
`endif
        if (rearm) begin
            state_d   = FILL;
            seg_cnt_d = '0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            timed_out_d = 1'b0;
`endif
        end else if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            prev_l_d  = samp_l;
            prev_r_d  = samp_r;
            seg_cnt_d = seg_next;
            unique case (state_q)
                FILL: begin
                    if (seg_next == FILL_LEN) begin
                        state_d   = ARMED;
                        seg_cnt_d = '0;
                    end
                end
                ARMED: begin
                    if (crossing) begin
                        state_d    = POST;
                        seg_cnt_d  = '0;
                        trig_ptr_d = wr_ptr_q;
                    end
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
                    else if (seg_next == TIMEOUT_LEN) begin
                        state_d     = POST;
                        seg_cnt_d   = '0;
                        trig_ptr_d  = wr_ptr_q;
                        timed_out_d = 1'b1;
                    end
`endif
                end
                POST: begin
                    if (seg_next == POST_LEN) begin
                        state_d   = DONE;
                        seg_cnt_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and pointer registers; capture restarts in FILL out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            dec_cnt_q  <= '0;
            dec_sel_q  <= '0;
            seg_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            prev_l_q   <= '0;
            prev_r_q   <= '0;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dec_cnt_q  <= dec_cnt_d;
            dec_sel_q  <= dec_sel_d;
            seg_cnt_q  <= seg_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            prev_l_q   <= prev_l_d;
            prev_r_q   <= prev_r_d;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign busy = (state_q != DONE);
    assign done = (state_q == DONE);

    // Logical index 0 is the oldest sample, PRE_TRIG samples before the trigger.
    assign rd_phys = trig_ptr_q - PRE_OFS + rd_addr;

    wave_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({samp_l, samp_r}),
        .rd_addr (rd_phys),
        .rd_data (rd_data)
    );

    assign rd_l = rd_data[2*DATA_W-1 -: DATA_W];
    assign rd_r = rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed bench for wave_capture with default parameters.
// Ramps with known zero crossings give hand-computable readout windows.
module tb_wave_capture;

    localparam int DEPTH    = 512;
    localparam int DATA_W   = 12;
    localparam int PRE_TRIG = 128;
    localparam int TIMEOUT  = 4096;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     sample_stb = 1'b0;
    logic [23:0]              audio_l = '0;
    logic [23:0]              audio_r = '0;
    logic [2:0]               dec_sel = '0;
    logic                     trig_ch = 1'b0;
    logic signed [DATA_W-1:0] trig_level = '0;
    logic                     rearm = 1'b0;
    logic                     busy, done, timed_out;
    logic [8:0]               rd_addr = '0;
    logic [DATA_W-1:0]        rd_l, rd_r;

    int total = 0;
    int bad = 0;

    // Stimulus generator settings: left = k - l_ofs, right = 3k (top 12 bits).
    int l_ofs = 200;
    int dec_fac = 1;
    bit dc_mode = 1'b0;

    typedef struct {
        int          cap;
        int          addr;
        logic [11:0] l;
        logic [11:0] r;
    } vec_t;

    vec_t vecs[$];

    wave_capture #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .PRE_TRIG (PRE_TRIG),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .dec_sel    (dec_sel),
        .trig_ch    (trig_ch),
        .trig_level (trig_level),
        .rearm      (rearm),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out),
        .rd_addr    (rd_addr),
        .rd_l       (rd_l),
        .rd_r       (rd_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] gen_l(input int k);
        if (dc_mode) return 24'h100000;
        return {12'(k - l_ofs), 12'hA5C};
    endfunction

    function automatic logic [23:0] gen_r(input int k);
        if (dc_mode) return 24'h100000;
        return {12'(3 * k), 12'h3F1};
    endfunction

    // Expected readout for the ramp captures, trigger at stored index 200.
    function automatic logic [11:0] exp_l(input int a);
        int k;
        k = dec_fac * (200 - PRE_TRIG + a);
        if (dc_mode) return 12'h100;
        return 12'(k - l_ofs);
    endfunction

    function automatic logic [11:0] exp_r(input int a);
        int k;
        k = dec_fac * (200 - PRE_TRIG + a);
        if (dc_mode) return 12'h100;
        return 12'(3 * k);
    endfunction

    // Strobe every cycle until done rises or the budget runs out (n = -1).
    task automatic applyStimulus(input int max_strobes, output int n);
        n = -1;
        for (int k = 0; k < max_strobes; k++) begin
            audio_l = gen_l(k);
            audio_r = gen_r(k);
            sample_stb = 1'b1;
            @(posedge clk);
            #1;
            if (done) begin
                n = k + 1;
                break;
            end
        end
        sample_stb = 1'b0;
    endtask

    task automatic applyBurst(input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            audio_l = gen_l(k);
            audio_r = gen_r(k);
            sample_stb = 1'b1;
            @(posedge clk);
            #1;
        end
        sample_stb = 1'b0;
    endtask

    task automatic pulseRearm();
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
    endtask

    task automatic checkTable(input int cap, input string tag);
        foreach (vecs[i]) begin
            if (vecs[i].cap == cap) begin
                rd_addr = 9'(vecs[i].addr);
                @(posedge clk);
                #1;
                checkOutput($sformatf("%s_l[%0d]", tag, vecs[i].addr), rd_l, vecs[i].l);
                checkOutput($sformatf("%s_r[%0d]", tag, vecs[i].addr), rd_r, vecs[i].r);
            end
        end
    endtask

    // New address every cycle; each result must belong to the address one edge earlier.
    task automatic checkSweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 9'(a);
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_l[%0d]", tag, a), rd_l, exp_l(a));
            checkOutput($sformatf("%s_r[%0d]", tag, a), rd_r, exp_r(a));
        end
    endtask

    initial begin
        int n;

        vecs.push_back('{1, 0,   12'hF80, 12'h0D8});
        vecs.push_back('{1, 127, 12'hFFF, 12'h255});
        vecs.push_back('{1, 128, 12'h000, 12'h258});
        vecs.push_back('{1, 255, 12'h07F, 12'h3D5});
        vecs.push_back('{1, 511, 12'h17F, 12'h6D5});
        vecs.push_back('{3, 0,   12'hC00, 12'h6C0});
        vecs.push_back('{3, 127, 12'hFF8, 12'h2A8});
        vecs.push_back('{3, 128, 12'h000, 12'h2C0});
        vecs.push_back('{3, 511, 12'hBF8, 12'h6A8});

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_timed_out", timed_out, 0);
        checkOutput("rst_rd_l", rd_l, 0);
        checkOutput("rst_rd_r", rd_r, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", busy, 1);

        $display("[TB] capture 1: left ramp, level 0");
        applyStimulus(2000, n);
        checkOutput("cap1_strobes", n, 584);
        checkOutput("cap1_busy", busy, 0);
        checkOutput("cap1_timed_out", timed_out, 0);
        applyBurst(584, 20);
        checkOutput("cap1_frozen_done", done, 1);
        checkTable(1, "cap1");
        checkSweep("cap1_sweep");

        $display("[TB] capture 2: right channel trigger, level 600");
        trig_ch = 1'b1;
        trig_level = 12'sd600;
        pulseRearm();
        checkOutput("cap2_rearm_done", done, 0);
        checkOutput("cap2_rearm_busy", busy, 1);
        applyStimulus(2000, n);
        checkOutput("cap2_strobes", n, 584);
        checkTable(1, "cap2");
        checkSweep("cap2_sweep");

        $display("[TB] capture 3: dec_sel=3");
        trig_ch = 1'b0;
        trig_level = '0;
        dec_sel = 3'd3;
        l_ofs = 1600;
        dec_fac = 8;
        pulseRearm();
        applyStimulus(6000, n);
        checkOutput("cap3_strobes", n, 4665);
        checkTable(3, "cap3");
        checkSweep("cap3_sweep");

        $display("[TB] rearm during POST together with a strobe");
        dec_sel = 3'd0;
        l_ofs = 200;
        dec_fac = 1;
        pulseRearm();
        applyBurst(0, 301);
        checkOutput("post_busy", busy, 1);
        checkOutput("post_done", done, 0);
        audio_l = gen_l(301);
        audio_r = gen_r(301);
        sample_stb = 1'b1;
        rearm = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        rearm = 1'b0;
        checkOutput("rearm_post_done", done, 0);
        checkOutput("rearm_post_busy", busy, 1);
        applyStimulus(2000, n);
        checkOutput("cap4_strobes", n, 584);
        checkTable(1, "cap4");

        $display("[TB] DC input below threshold crossing");
        dc_mode = 1'b1;
        trig_level = 12'sd300;
        pulseRearm();
        applyStimulus(5000, n);
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        checkOutput("dc_strobes", n, 128 + TIMEOUT + 383);
        checkOutput("dc_timed_out", timed_out, 1);
        checkOutput("dc_done", done, 1);
        rd_addr = 9'd0;
        @(posedge clk);
        #1;
        checkOutput("dc_rd_l0", rd_l, 12'h100);
        rd_addr = 9'd511;
        @(posedge clk);
        #1;
        checkOutput("dc_rd_r511", rd_r, 12'h100);
`else
        checkOutput("dc_no_done", n, 32'hFFFF_FFFF);
        checkOutput("dc_busy", busy, 1);
        checkOutput("dc_timed_out", timed_out, 0);
`endif

        $display("[TB] reset while armed");
        pulseRearm();
        rd_addr = 9'd5;
        applyBurst(0, 200);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_done", done, 0);
        checkOutput("arst_timed_out", timed_out, 0);
        checkOutput("arst_rd_l", rd_l, 0);
        checkOutput("arst_rd_r", rd_r, 0);
        checkOutput("arst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_release_busy", busy, 1);
        dc_mode = 1'b0;
        trig_level = '0;
        applyStimulus(2000, n);
        checkOutput("cap5_strobes", n, 584);
        checkTable(1, "cap5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
